image_frame_sequencer: RTL and testbench
========================================

Name: image_frame_sequencer

Overview:
Frame-level controller that sequences one image from the pixel store, through the per-pixel operation, to the writer sink. On a start pulse it scans every pixel address, applies the selected pixel operation and presents pixels on a ready/valid stream to the writer. Pixels carry row/column tags and frame markers. One instance replaces the free-running per-module read loops and lets invert, grayscale and threshold share a single datapath selected at runtime.

Parameters:
WIDTH, 512, pixels per row
HEIGHT, 768, rows per frame
ADDR_W, 19, pixel-store address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT
FLIP_ROWS, 1, 1 = emit rows HEIGHT-1 down to 0 (BMP bottom-up order); 0 = rows 0 up to HEIGHT-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
mode  in  2  0 pass, 1 invert, 2 grayscale, 3 threshold; latched at start
thresh  in  8  threshold level; latched at start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last pixel handshake
rd_en  out  1  pixel-store read strobe
rd_addr  out  ADDR_W  pixel index, row*WIDTH+col
rd_data  in  24  {R,G,B}; valid exactly 1 cycle after rd_en
out_valid  out  1  output pixel valid
out_ready  in  1  writer accepts the pixel
R, G, B  out  8 each  processed pixel
out_row  out  16  source row of the output pixel
out_col  out  16  source column of the output pixel
out_sof, out_eol, out_eof  out  1 each  first pixel of frame / col==WIDTH-1 / last pixel of frame

Behaviour:
- Reset: state IDLE; FIFO and in-flight flag cleared; all outputs 0.
- FSM:
  - IDLE -> RUN on start. Captures mode and thresh. Read counter is set to (FLIP_ROWS ? HEIGHT-1 : 0, 0).
  - RUN -> DRAIN when the last read has been issued.
  - DRAIN -> DONE when the FIFO is empty and no read is in flight.
  - DONE -> IDLE after 1 cycle.
- done is asserted in the DONE cycle. busy is 0 in IDLE and DONE.
- start while busy: ignored. mode/thresh changes mid-frame: ignored.
- Output buffer: 2-entry FIFO. Processed rd_data is written into it on the edge after rd_en.
  - rd_en is issued only if (fifo_count + inflight) < 2, or == 2 with a pop in the same cycle.
  - This guarantees no overflow and no pixel loss or duplication.
- Latency and throughput: first out_valid appears 3 cycles after the edge that samples start. With out_ready held high, throughput is 1 pixel/clk.
- Scan order:
  - Column 0..WIDTH-1 within a row.
  - Row step: -1 if FLIP_ROWS, else +1.
  - Last read is (row 0, col WIDTH-1) when flipped, else (HEIGHT-1, WIDTH-1).
  - The row/col/marker tags travel through the FIFO with the pixel.
- Pixel operation (combinational, before the FIFO write):
  - pass: unchanged.
  - invert: each channel becomes 255-x.
  - grayscale: y = (R + 2G + B) >> 2, computed in 10 bits, truncated; R=G=B=y.
  - threshold: y computed as for grayscale; then R=G=B = (y >= thresh) ? 255 : 0.
- Valid/ready: once out_valid rises, it and the data stay stable until out_ready. Handshake occurs when both are high.
- Reset mid-frame: immediate return to IDLE. The FIFO is flushed, no done pulse is produced, and the in-flight rd_data is discarded.

Optional Feature:
IMG_SEQ_ABORT_EN:
- Defined: adds input abort (1 bit).
  - In RUN or DRAIN, abort stops new reads and flushes the FIFO. out_valid drops the next cycle, and the FSM goes to DONE, which pulses done.
  - abort in IDLE is ignored.
- Undefined: no port; the frame always runs to completion.

Decomposition:
- Package img_pkg holds:
  - mode encodings (MODE_PASS, MODE_INV, MODE_GRAY, MODE_THR);
  - the FSM state enum (IDLE, RUN, DRAIN, DONE);
  - the grayscale weight/shift constants;
  - the pixel struct {r, g, b}.
- Sub-module img_pixel_op: combinational (mode, thresh, rgb_in) -> rgb_out, shared with future filters. The FIFO stays inline.

Test Plan:
- WIDTH=4, HEIGHT=3, FLIP_ROWS=1, mode pass, out_ready=1, start → rd_addr 8..11, 4..7, 0..3; 12 outputs, first at start+3 cycles; out_sof on the first pixel; out_eol at addrs 11, 7, 3; out_eof on addr 3; done 1 cycle after the last handshake.
- Pixel modes:
  - grayscale on rd_data {100,50,200} → R=G=B=100;
  - invert on the same pixel → {155,205,55};
  - threshold with thresh=100 → 255, with thresh=101 → 0.
- Random out_ready (50% duty) over a 4x3 frame → all 12 pixels in order exactly once; data stable while out_valid && !out_ready; rd_en never drives the FIFO past 2.
- start re-pulsed at pixel 5, and mode changed mid-frame → no restart; the frame completes with the original mode; exactly one done.
- rst asserted at pixel 6 → next cycle all outputs 0 and state IDLE; no done; a new start produces a clean full frame beginning at addr 8.
- IMG_SEQ_ABORT_EN: abort at pixel 4 with out_ready=0 → no further rd_en; out_valid low next cycle; done pulses once; busy low afterwards.

Source files
------------

// File: rtl/image_frame_sequencer_pkg.sv
// Shared types and constants for the image frame sequencer and its per-pixel datapath.
// Holds the mode encodings, FSM states, grayscale weights and the pixel/tag records.
package img_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_GRAY = 2'd2,
        MODE_THR  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Luma weights as left-shift amounts (1, 2, 1), then a divide by 4.
    localparam int GRAY_SHL_R = 0;
    localparam int GRAY_SHL_G = 1;
    localparam int GRAY_SHL_B = 0;
    localparam int GRAY_SHIFT = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef struct packed {
        logic [15:0] row;
        logic [15:0] col;
        logic        sof;
        logic        eol;
        logic        eof;
    } tag_t;

    typedef struct packed {
        pixel_t pix;
        tag_t   tag;
    } entry_t;

    function automatic logic [7:0] gray_level(input pixel_t p);
        logic [9:0] sum;
        sum = ({2'b00, p.r} << GRAY_SHL_R) + ({2'b00, p.g} << GRAY_SHL_G) + ({2'b00, p.b} << GRAY_SHL_B);
        return sum[GRAY_SHIFT +: 8];
    endfunction

endpackage

// File: rtl/image_frame_sequencer_if.sv
// Pixel-store read port and writer-side ready/valid pixel stream of the frame sequencer.
// The master modport is the sequencer; the slave modport is the store/writer side.
interface image_frame_sequencer_if #(
    parameter int ADDR_W = 19
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [23:0]       rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        R;
    logic [7:0]        G;
    logic [7:0]        B;
    logic [15:0]       out_row;
    logic [15:0]       out_col;
    logic              out_sof;
    logic              out_eol;
    logic              out_eof;

    modport master (
        output rd_en, rd_addr, out_valid, R, G, B, out_row, out_col, out_sof, out_eol, out_eof,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_valid, R, G, B, out_row, out_col, out_sof, out_eol, out_eof,
        output rd_data, out_ready
    );
endinterface

// File: rtl/image_frame_sequencer_pixel_op.sv
// Combinational per-pixel operation (pass, invert, grayscale, threshold), shared by
// the frame sequencer and future filters.
module img_pixel_op
    import img_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [7:0] thresh,
    input  pixel_t     rgb_in,
    output pixel_t     rgb_out
);

    logic [7:0] y_s;
    logic [7:0] bin_s;

    // Select the transform; 255-x is the bitwise complement for 8-bit channels.
    always_comb begin
        y_s = gray_level(rgb_in);
        if (y_s >= thresh) begin
            bin_s = 8'hFF;
        end else begin
            bin_s = 8'h00;
        end
        case (mode)
            MODE_PASS: rgb_out = rgb_in;
            MODE_INV:  rgb_out = ~rgb_in;
            MODE_GRAY: rgb_out = {y_s, y_s, y_s};
            MODE_THR:  rgb_out = {bin_s, bin_s, bin_s};
            default:   rgb_out = rgb_in;
        endcase
    end

endmodule

// File: rtl/image_frame_sequencer.sv
// Frame sequencer: scans the pixel store, applies the selected pixel operation and streams
// tagged pixels through a 2-entry FIFO. Optional abort input when IMG_SEQ_ABORT_EN is defined.
module image_frame_sequencer
    import img_pkg::*;
#(
    parameter int WIDTH     = 512,
    parameter int HEIGHT    = 768,
    parameter int ADDR_W    = 19,
    parameter int FLIP_ROWS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [7:0] thresh,
`ifdef IMG_SEQ_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       done,
    image_frame_sequencer_if.master bus
);

    localparam logic [15:0] ROW_FIRST = (FLIP_ROWS != 0) ? 16'(HEIGHT - 1) : 16'd0;
    localparam logic [15:0] ROW_LAST  = (FLIP_ROWS != 0) ? 16'd0 : 16'(HEIGHT - 1);
    localparam logic [15:0] COL_LAST  = 16'(WIDTH - 1);

    state_e      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  thresh_q, thresh_d;
    logic [15:0] row_q, row_d;
    logic [15:0] col_q, col_d;
    logic        first_q, first_d;
    logic        dv_q, dv_d;
    tag_t        dv_tag_q, dv_tag_d;
    entry_t      fifo_q [2];
    entry_t      fifo_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic              abort_s;
    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic              last_rd_s;
    logic              drained_s;
    logic [2:0]        occ_s;
    logic [ADDR_W-1:0] rd_addr_s;
    pixel_t            rd_pix_s;
    pixel_t            op_pix_s;
    entry_t            head_s;

`ifdef IMG_SEQ_ABORT_EN
    assign abort_s = abort && ((state_q == RUN) || (state_q == DRAIN));
`else
    assign abort_s = 1'b0;
`endif

    assign rd_pix_s  = bus.rd_data;
    assign last_rd_s = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign rd_addr_s = ADDR_W'(row_q) * ADDR_W'(WIDTH) + ADDR_W'(col_q);
    assign push_s    = dv_q && !abort_s;
    assign drained_s = !dv_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop_s));

    img_pixel_op u_pixel_op (
        .mode    (mode_q),
        .thresh  (thresh_q),
        .rgb_in  (rd_pix_s),
        .rgb_out (op_pix_s)
    );

    // Read credit: FIFO entries plus the pixel arriving this cycle never exceed two.
    always_comb begin
        occ_s = {1'b0, count_q} + {2'b00, dv_q};
        pop_s = (count_q != 2'd0) && bus.out_ready;
        if ((state_q == RUN) && !abort_s) begin
            issue_s = (occ_s < 3'd2) || ((occ_s == 3'd2) && pop_s);
        end else begin
            issue_s = 1'b0;
        end
    end

    // Frame FSM and scan counters.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        thresh_d = thresh_q;
        row_d    = row_q;
        col_d    = col_q;
        first_d  = first_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    mode_d   = mode;
                    thresh_d = thresh;
                    row_d    = ROW_FIRST;
                    col_d    = 16'd0;
                    first_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort_s) begin
                    state_d = DONE;
                end else if (issue_s) begin
                    first_d = 1'b0;
                    if (col_q == COL_LAST) begin
                        col_d = 16'd0;
                        row_d = (FLIP_ROWS != 0) ? (row_q - 16'd1) : (row_q + 16'd1);
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                    if (last_rd_s) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (abort_s || drained_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In-flight read tracking and the 2-entry output FIFO; tags ride along with the pixel.
    always_comb begin
        dv_d     = issue_s;
        dv_tag_d = dv_tag_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (issue_s) begin
            dv_tag_d = {row_q, col_q, first_q, (col_q == COL_LAST), last_rd_s};
        end else begin
            dv_tag_d = dv_tag_q;
        end
        if (abort_s) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_s) begin
                fifo_d[wr_ptr_q] = {op_pix_s, dv_tag_q};
                wr_ptr_d         = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
        end
        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    // State registers with synchronous reset; a reset also drops the in-flight pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= 2'd0;
            thresh_q <= 8'd0;
            row_q    <= 16'd0;
            col_q    <= 16'd0;
            first_q  <= 1'b0;
            dv_q     <= 1'b0;
            dv_tag_q <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            thresh_q <= thresh_d;
            row_q    <= row_d;
            col_q    <= col_d;
            first_q  <= first_d;
            dv_q     <= dv_d;
            dv_tag_q <= dv_tag_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign head_s        = fifo_q[rd_ptr_q];
    assign bus.rd_en     = issue_s;
    assign bus.rd_addr   = issue_s ? rd_addr_s : '0;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.R         = head_s.pix.r;
    assign bus.G         = head_s.pix.g;
    assign bus.B         = head_s.pix.b;
    assign bus.out_row   = head_s.tag.row;
    assign bus.out_col   = head_s.tag.col;
    assign bus.out_sof   = head_s.tag.sof;
    assign bus.out_eol   = head_s.tag.eol;
    assign bus.out_eof   = head_s.tag.eof;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Directed bench for image_frame_sequencer on a 4x3 bottom-up frame; abort scenario is
// compiled in when IMG_SEQ_ABORT_EN is defined.
module tb_image_frame_sequencer;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int AW   = 4;
    localparam int NPIX = W * H;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [7:0] thresh;
    logic       busy;
    logic       done;
`ifdef IMG_SEQ_ABORT_EN
    logic       abort;
`endif

    logic [23:0] mem [16];
    int n_vec  = 0;
    int n_miss = 0;

    image_frame_sequencer_if #(.ADDR_W(AW)) bus ();

    image_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .FLIP_ROWS(1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .thresh (thresh),
`ifdef IMG_SEQ_ABORT_EN
        .abort  (abort),
`endif
        .busy   (busy),
        .done   (done),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel store: registered read, data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input int k);
        int row;
        row = (H - 1) - k / W;
        return AW'(row * W + k % W);
    endfunction

    function automatic logic [34:0] exp_tag(input int k);
        int row;
        int col;
        row = (H - 1) - k / W;
        col = k % W;
        return {16'(row), 16'(col), (k == 0), (col == W - 1), (k == NPIX - 1)};
    endfunction

    task automatic fill_pattern();
        for (int i = 0; i < 16; i++) mem[i] = {8'(17 * i + 3), 8'(29 * i), 8'(250 - 7 * i)};
    endtask

    task automatic check_idle_outputs(input string tag);
        check_value({tag, "_ctrl"}, {busy, done, bus.rd_en, bus.rd_addr, bus.out_valid}, 64'd0);
        check_value({tag, "_data"}, {bus.R, bus.G, bus.B, bus.out_row, bus.out_col,
                                     bus.out_sof, bus.out_eol, bus.out_eof}, 64'd0);
    endtask

    // One frame; expected pixel is fixed_px, or the stored pixel (complemented when inv).
    task automatic run_frame(input logic [1:0] m, input logic [7:0] th, input bit rnd,
                             input bit fixed, input logic [23:0] fixed_px, input bit inv,
                             input int restart_at, input int reset_at);
        int hs, reads, dones, first_vld, last_hs, max_out;
        bit stall_prev, restarted;
        logic [59:0] snap, snap_prev;
        logic [AW-1:0] a;
        logic [23:0] exp_px;
        hs = 0; reads = 0; dones = 0; first_vld = -1; last_hs = -100; max_out = 0;
        stall_prev = 1'b0; restarted = 1'b0; snap_prev = '0;
        start = 1'b1; mode = m; thresh = th;
        @(posedge clk); #1;
        start = 1'b0;
        check_value("busy_after_start", busy, 1);
        for (int cyc = 1; cyc < 200; cyc++) begin
            if (reads - hs > max_out) max_out = reads - hs;
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (restart_at >= 0 && hs >= restart_at && !restarted) begin
                start = 1'b1; mode = ~m; thresh = ~th; restarted = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (reset_at >= 0 && hs == reset_at) begin
                rst = 1'b1;
                break;
            end
            #1;
            snap = {bus.out_valid, bus.R, bus.G, bus.B, bus.out_row, bus.out_col,
                    bus.out_sof, bus.out_eol, bus.out_eof};
            if (stall_prev) check_value("stable_on_stall", snap, snap_prev);
            if (bus.rd_en) begin
                check_value("rd_addr", bus.rd_addr, exp_addr(reads));
                reads++;
            end
            if (bus.out_valid && first_vld < 0) first_vld = cyc;
            if (done) begin
                dones++;
                check_value("done_timing", cyc, last_hs + 1);
                check_value("busy_in_done", busy, 0);
            end
            if (bus.out_valid && bus.out_ready) begin
                a = exp_addr(hs);
                exp_px = fixed ? fixed_px : (inv ? ~mem[a] : mem[a]);
                check_value("pixel", {bus.R, bus.G, bus.B}, exp_px);
                check_value("tags", {bus.out_row, bus.out_col, bus.out_sof, bus.out_eol, bus.out_eof},
                            exp_tag(hs));
                hs++;
                last_hs = cyc;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            snap_prev  = snap;
            if (dones > 0 && cyc > last_hs + 3) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (reset_at >= 0) begin
            rst = 1'b1;
            check_value("hs_before_reset", hs, reset_at);
            @(posedge clk); #1;
            check_idle_outputs("after_reset");
            rst = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                dones += int'(done);
            end
            check_value("no_done_after_reset", dones, 0);
        end else begin
            check_value("handshakes", hs, NPIX);
            check_value("reads", reads, NPIX);
            check_value("done_count", dones, 1);
            check_value("first_valid_cycle", first_vld, 3);
            check_value("outstanding_le_2", (max_out <= 2), 1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'd0; thresh = 8'd0;
        bus.out_ready = 1'b0;
`ifdef IMG_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        fill_pattern();
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame(2'd0, 8'd0, 1'b0, 1'b0, 24'h0, 1'b0, -1, -1);

        for (int i = 0; i < 16; i++) mem[i] = 24'h6432C8;
        run_frame(2'd2, 8'd0,   1'b0, 1'b1, 24'h646464, 1'b0, -1, -1);
        run_frame(2'd1, 8'd0,   1'b0, 1'b1, 24'h9BCD37, 1'b0, -1, -1);
        run_frame(2'd3, 8'd100, 1'b0, 1'b1, 24'hFFFFFF, 1'b0, -1, -1);
        run_frame(2'd3, 8'd101, 1'b0, 1'b1, 24'h000000, 1'b0, -1, -1);

        fill_pattern();
        run_frame(2'd0, 8'd0, 1'b1, 1'b0, 24'h0, 1'b0, -1, -1);
        run_frame(2'd1, 8'd0, 1'b0, 1'b0, 24'h0, 1'b1, 5, -1);
        run_frame(2'd0, 8'd0, 1'b0, 1'b0, 24'h0, 1'b0, -1, 6);
        run_frame(2'd0, 8'd0, 1'b0, 1'b0, 24'h0, 1'b0, -1, -1);

`ifdef IMG_SEQ_ABORT_EN
        begin
            int hs_a;
            int any_a;
            hs_a = 0; any_a = 0;
            start = 1'b1; mode = 2'd0;
            @(posedge clk); #1;
            start = 1'b0;
            for (int cyc = 0; cyc < 50 && hs_a < 4; cyc++) begin
                bus.out_ready = 1'b1;
                #1;
                if (bus.out_valid) hs_a++;
                @(posedge clk); #1;
            end
            check_value("abort_reached_px4", hs_a, 4);
            bus.out_ready = 1'b0;
            abort = 1'b1;
            #1;
            check_value("abort_no_read", bus.rd_en, 0);
            @(posedge clk); #1;
            abort = 1'b0;
            check_value("abort_next_cycle", {bus.out_valid, done, busy}, 3'b010);
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                any_a += int'(bus.rd_en) + int'(done) + int'(busy) + int'(bus.out_valid);
            end
            check_value("abort_quiet_after", any_a, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
